// File: rtl/fp_subtractor.sv
// rtl/fp_subtractor.sv - multi-cycle IEEE-754 single-precision subtractor (truncating)
module fp_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    SUB   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  // captured operands
  logic [31:0] a_r, b_r;

  // aligned operands
  logic        big_sign, small_sign;
  logic [7:0]  big_exp;
  logic [23:0] big_man, small_man;

  // working result
  logic        res_sign;
  logic [7:0]  res_exp;
  logic [24:0] res_man;

  // unpack / align helpers
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        a_is_big;
  logic [7:0]  exp_diff;
  logic [23:0] small_raw;
  logic [23:0] small_shifted;
  logic [8:0]  exp_inc;
  logic        norm_done;

  // Unpack both captured operands; zero exponent field is a denormal (exp 1, hidden 0).
  always_comb begin
    ea            = (a_r[30:23] == 8'd0) ? 8'd1 : a_r[30:23];
    eb            = (b_r[30:23] == 8'd0) ? 8'd1 : b_r[30:23];
    ma            = {(a_r[30:23] != 8'd0), a_r[22:0]};
    mb            = {(b_r[30:23] != 8'd0), b_r[22:0]};
    a_is_big      = (ea > eb) || ((ea == eb) && (ma >= mb));
    exp_diff      = a_is_big ? (ea - eb) : (eb - ea);
    small_raw     = a_is_big ? mb : ma;
    small_shifted = (exp_diff >= 8'd25) ? 24'd0 : (small_raw >> exp_diff);
    exp_inc       = {1'b0, res_exp} + 9'd1;
    norm_done     = (res_man == 25'd0) || res_man[24] || res_man[23] || (res_exp == 8'd1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? ALIGN : IDLE;
      ALIGN:   state_next = SUB;
      SUB:     state_next = NORM;
      NORM:    state_next = norm_done ? DONE : NORM;
      DONE:    state_next = start ? ALIGN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, align, add/subtract magnitudes, normalise and pack.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      big_exp    <= 8'd0;
      big_man    <= 24'd0;
      small_man  <= 24'd0;
      res_sign   <= 1'b0;
      res_exp    <= 8'd0;
      res_man    <= 25'd0;
      out        <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
          end
        end
        ALIGN: begin
          // b's sign is inverted so the operation becomes a + (-b)
          big_sign   <= a_is_big ? a_r[31] : ~b_r[31];
          small_sign <= a_is_big ? ~b_r[31] : a_r[31];
          big_exp    <= a_is_big ? ea : eb;
          big_man    <= a_is_big ? ma : mb;
          small_man  <= small_shifted;
        end
        SUB: begin
          // big >= small in magnitude, so the difference never goes negative
          res_man  <= (big_sign == small_sign) ? ({1'b0, big_man} + {1'b0, small_man})
                                               : ({1'b0, big_man} - {1'b0, small_man});
          res_sign <= big_sign;
          res_exp  <= big_exp;
        end
        NORM: begin
          if (res_man == 25'd0) begin
            out <= 32'd0;
          end else if (res_man[24]) begin
            if (exp_inc == 9'd255) out <= {res_sign, 8'hFF, 23'd0};
            else                   out <= {res_sign, exp_inc[7:0], res_man[23:1]};
          end else if (res_man[23]) begin
            out <= {res_sign, res_exp, res_man[22:0]};
          end else if (res_exp == 8'd1) begin
            out <= {res_sign, 8'h00, res_man[22:0]};
          end else begin
            res_man <= {res_man[23:0], 1'b0};
            res_exp <= res_exp - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ALIGN) || (state == SUB) || (state == NORM);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fp_subtractor.sv
// tb/tb_fp_subtractor.sv - self-checking bench for fp_subtractor
module tb_fp_subtractor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int passed;
  int total;

  fp_subtractor dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: real-valued rules on integer magnitudes; the left-shift count
  // is found from the leading-one position, limited by the exponent floor.
  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output int n);
    int     ex, ey, e_big, e_sml, d, e, p;
    longint mx, my, m_big, m_sml, m;
    logic   sx, sy, s_big, s_sml;
    ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
    mx = ((x[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + longint'(x[22:0]);
    my = ((y[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + longint'(y[22:0]);
    sx = x[31];
    sy = ~y[31];
    if (ex > ey || (ex == ey && mx >= my)) begin
      e_big = ex; m_big = mx; s_big = sx; e_sml = ey; m_sml = my; s_sml = sy;
    end else begin
      e_big = ey; m_big = my; s_big = sy; e_sml = ex; m_sml = mx; s_sml = sx;
    end
    d = e_big - e_sml;
    if (d >= 25) m_sml = 0;
    else         m_sml = m_sml >> d;
    m = (s_big == s_sml) ? (m_big + m_sml) : (m_big - m_sml);
    e = e_big;
    n = 0;
    if (m == 0) begin
      r = 32'd0;
    end else if (m >= 64'd16777216) begin
      e = e + 1;
      m = m >> 1;
      if (e >= 255) r = {s_big, 8'hFF, 23'd0};
      else          r = {s_big, 8'(e), 23'(m)};
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (m[i]) p = i;
      n = 23 - p;
      if (n > e - 1) n = e - 1;
      m = m << n;
      e = e - n;
      if (m[23]) r = {s_big, 8'(e), 23'(m)};
      else       r = {s_big, 8'h00, 23'(m)};
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_r, input int exp_lat, input string name);
    int edges;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    total++;
    if (edges !== exp_lat)
      $display("FAIL %s latency a=%h b=%h got %0d edges expected %0d", name, x, y, edges, exp_lat);
    else passed++;
    total++;
    if (out !== exp_r)
      $display("FAIL %s out a=%h b=%h got %h expected %h", name, x, y, out, exp_r);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out !== 32'd0) $display("FAIL reset_out got %h expected 00000000", out); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL reset_done got %b expected 0", done); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 3,  "three_minus_one");
    run_op(32'h3F800000, 32'h3F800000, 32'h00000000, 3,  "equal_zero");
    run_op(32'h3F800000, 32'hBF800000, 32'h40000000, 3,  "carry_path");
    run_op(32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 26, "cancel_n23");
    run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3,  "overflow_inf");
  endtask

  task automatic test_done_pulse();
    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 3, "pulse_op");
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) $display("FAIL done_pulse got %b expected 0", done); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL idle_busy got %b expected 0", busy); else passed++;
    total++;
    if (out !== 32'h40000000) $display("FAIL out_hold got %h expected 40000000", out); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int n;
    model(32'h41200000, 32'h40A00000, r, n);
    run_op(32'h41200000, 32'h40A00000, r, 3 + n, "b2b_first");
    model(32'hC0000000, 32'h3F000000, r, n);
    run_op(32'hC0000000, 32'h3F000000, r, 3 + n, "b2b_second");
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] x, y, r;
    int n, ex, ey;
    for (int k = 0; k < 150; k++) begin
      ex = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 254));
      if ($urandom_range(0, 1) == 1) ey = int'($urandom_range(0, 254));
      else begin
        ey = ex + int'($urandom_range(0, 4)) - 2;
        if (ey < 0) ey = 0;
        if (ey > 254) ey = 254;
      end
      x = {1'($urandom), 8'(ex), 23'($urandom)};
      y = {1'($urandom), 8'(ey), 23'($urandom)};
      if ($urandom_range(0, 5) == 0) y[22:0] = x[22:0] ^ 23'($urandom_range(0, 3));
      model(x, y, r, n);
      run_op(x, y, r, 3 + n, "random");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int edges;
    a = 32'h40400000;
    b = 32'h3F800000;
    start = 1'b1;
    @(posedge clk); #1;
    a = 32'h7F7FFFFF;
    b = 32'hFF7FFFFF;
    edges = 0;
    while (done !== 1'b1 && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    total++;
    if (edges !== 3) $display("FAIL busy_ignore_latency got %0d expected 3", edges); else passed++;
    total++;
    if (out !== 32'h40000000) $display("FAIL busy_ignore_out got %h expected 40000000", out); else passed++;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) $display("FAIL busy_ignore_done_after got %b expected 0", done); else passed++;
  endtask

  task automatic test_reset_mid_norm();
    bit seen_done;
    a = 32'h3F800000;
    b = 32'h3F7FFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) $display("FAIL mid_norm_busy got %b expected 1", busy); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0) $display("FAIL abort_busy got %b expected 0", busy); else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL abort_done got %b expected 0", done); else passed++;
    total++;
    if (out !== 32'd0) $display("FAIL abort_out got %h expected 00000000", out); else passed++;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) $display("FAIL abort_late_done got %b expected 0", seen_done); else passed++;
    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 3, "fresh_after_reset");
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_directed();
    test_done_pulse();
    test_back_to_back();
    test_random();
    test_start_ignored();
    test_reset_mid_norm();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
